flush_stall_ctrl: RTL

- Parametrised multi-source flush/stall controller for the riscv32I pipeline; successor to the fixed 2-code flush_stall FSM.
- Arbitrates NUM_SRC flush requesters.
- Each requester either asks for a programmable number of stall periods or holds the stall open by level.
- State updates only on the pipeline phase tick (cycle_cnt == UPDATE_PHASE).
- Drives a registered flush_stall to the fetch/decode stages.

---
 rtl/flush_pkg.sv | 10 +
 rtl/flush_src_arbiter.sv | 34 +++
 rtl/flush_stall_ctrl.sv | 68 ++++++
 3 files changed

// File: rtl/flush_pkg.sv
// flush_pkg: shared state encoding, default phase and depth-slice helper for the flush/stall controller
package flush_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam int UPDATE_PHASE_DEF = 4;
  function automatic int depth_lsb(input int i, input int w);
    return i * w;
  endfunction
endpackage

// File: rtl/flush_src_arbiter.sv
// flush_src_arbiter: lowest-index priority pick, any hold beats any counted request with nonzero depth
module flush_src_arbiter import flush_pkg::*; #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH_W = 3
) (
  input  logic [NUM_SRC-1:0]         hold,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC*DEPTH_W-1:0] depth_vec,
  output logic                       hold_hit,
  output logic                       req_hit,
  output logic [NUM_SRC-1:0]         grant,
  output logic [DEPTH_W-1:0]         sel_depth
);
  logic [NUM_SRC-1:0] valid;
  assign hold_hit = |hold;
  assign req_hit = |valid;
  // zero-depth requests drop out here so they never win
  always_comb begin
    valid = '0;
    for (int i = 0; i < NUM_SRC; i++)
      valid[i] = req[i] && (depth_vec[depth_lsb(i, DEPTH_W) +: DEPTH_W] != '0);
  end
  // scan high to low so the lowest-index candidate is the last one written
  always_comb begin
    grant = '0;
    sel_depth = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (hold_hit ? hold[i] : valid[i]) begin
        grant = '0;
        grant[i] = 1'b1;
        sel_depth = depth_vec[depth_lsb(i, DEPTH_W) +: DEPTH_W];
      end
  end
endmodule

// File: rtl/flush_stall_ctrl.sv
// flush_stall_ctrl: multi-source flush/stall FSM advancing only on the pipeline phase tick
module flush_stall_ctrl import flush_pkg::*; #(
  parameter int CNT_W = 4,
  parameter int UPDATE_PHASE = UPDATE_PHASE_DEF,
  parameter int NUM_SRC = 2,
  parameter int DEPTH_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CNT_W-1:0]           cycle_cnt,
  input  logic [NUM_SRC-1:0]         flush_req,
  input  logic [NUM_SRC*DEPTH_W-1:0] flush_depth,
  input  logic [NUM_SRC-1:0]         flush_hold,
  output logic                       flush_stall,
  output logic [DEPTH_W-1:0]         stall_remaining,
  output logic [NUM_SRC-1:0]         owner,
  output logic                       flush_done
);
  logic [1:0] state, next_state;
  logic tick, rearb, hold_hit, req_hit, stall_d, done_d;
  logic [NUM_SRC-1:0] grant, owner_d;
  logic [DEPTH_W-1:0] sel_depth, rem_d;
  assign tick = cycle_cnt == CNT_W'(UPDATE_PHASE);
  assign rearb = state == IDLE || (state == COUNT && stall_remaining <= DEPTH_W'(1));
  flush_src_arbiter #(.NUM_SRC(NUM_SRC), .DEPTH_W(DEPTH_W)) u_arb (
    .hold(flush_hold),
    .req(flush_req),
    .depth_vec(flush_depth),
    .hold_hit(hold_hit),
    .req_hit(req_hit),
    .grant(grant),
    .sel_depth(sel_depth)
  );
  // state and registered outputs; reset drops everything without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      flush_stall <= 1'b0;
      stall_remaining <= '0;
      owner <= '0;
      flush_done <= 1'b0;
    end else begin
      state <= next_state;
      flush_stall <= stall_d;
      stall_remaining <= rem_d;
      owner <= owner_d;
      flush_done <= done_d;
    end
  end
  // only the owner's hold keeps HOLD alive; the last COUNT period re-arbitrates like IDLE
  always_comb begin
    next_state = !tick ? state
               : rearb ? (hold_hit ? HOLD : req_hit ? COUNT : IDLE)
               : state == HOLD ? (|(flush_hold & owner) ? HOLD : COUNT)
               : state == COUNT ? COUNT : IDLE;
  end
  // next register values; leaving HOLD leaves one trailing stall period
  always_comb begin
    stall_d = next_state != IDLE;
    done_d = state == COUNT && next_state == IDLE;
    rem_d = next_state != COUNT ? '0
          : !tick ? stall_remaining
          : state == HOLD ? DEPTH_W'(1)
          : rearb ? sel_depth
          : stall_remaining - 1'b1;
    owner_d = next_state == IDLE ? '0 : (tick && rearb) ? grant : owner;
  end
endmodule
